// File: rtl/seq_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply with early exit and restoring divide.
// Operands are captured on start; results are only written on the edge that ends RUN.
module seq_muldiv #(
    parameter int N  = 16,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic         op_div,
    input  logic         op_signed,
    input  logic [N-1:0] ain,
    input  logic [N-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result_hi,
    output logic [N-1:0] result_lo,
    output logic         div_by_zero
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_div, r_sa, r_sb, r_dz, r_dbz;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_opb;     // multiplier (shifts right) or divisor
    logic [N-1:0]   r_q;       // dividend bits shift out as quotient bits shift in
    logic [N-1:0]   r_rem;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_res_hi, r_res_lo;

    logic           w_accept, w_finish, w_ge, w_bzero;
    logic [N-1:0]   w_abs_a, w_abs_b, w_rem_sub, w_quo, w_rem_fix;
    logic [N:0]     w_rem_sh;
    logic [2*N-1:0] w_prod;

    assign w_abs_a = (op_signed && ain[N-1]) ? -ain : ain;
    assign w_abs_b = (op_signed && bin[N-1]) ? -bin : bin;
    assign w_bzero = (bin == '0);

    // The shifted partial remainder carries one extra bit so divisors above 2^(N-1) compare correctly.
    assign w_rem_sh  = {r_rem, r_q[N-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub = w_rem_sh[N-1:0] - r_opb;

    assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo     = (r_sa ^ r_sb) ? -r_q : r_q;
    assign w_rem_fix = r_sa ? -r_rem : r_rem;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_dz || (r_div ? (r_cnt == CW'(N)) : (r_opb == '0))) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state  <= S_IDLE;
            r_div    <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_dbz    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_div   <= op_div;
                r_sa    <= op_signed & ain[N-1];
                r_sb    <= op_signed & bin[N-1];
                r_dz    <= op_div & w_bzero;
                r_dbz   <= 1'b0;
                r_acc   <= '0;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_mcand <= {{N{1'b0}}, w_abs_a};
                r_opb   <= w_abs_b;
                // A zero divisor reports the raw dividend, so keep it unmodified.
                r_q     <= (op_div && w_bzero) ? ain : w_abs_a;
            end else if (w_finish) begin
                if (r_dz) begin
                    r_res_hi <= r_q;
                    r_res_lo <= '1;
                    r_dbz    <= 1'b1;
                end else if (r_div) begin
                    r_res_hi <= w_rem_fix;
                    r_res_lo <= w_quo;
                end else begin
                    {r_res_hi, r_res_lo} <= w_prod;
                end
            end else if (r_state == S_RUN) begin
                if (r_div) begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_sh[N-1:0];
                    r_q   <= {r_q[N-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end else begin
                    if (r_opb[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_opb   <= r_opb >> 1;
                end
            end
        end
    end

    assign done        = (r_state == S_IDLE);
    assign busy        = ~done;
    assign result_hi   = r_res_hi;
    assign result_lo   = r_res_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv: stimulus pushes model results, a negedge monitor pops and compares on done.
module tb_seq_muldiv;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         resetb;
    logic         start, op_div, op_signed;
    logic [N-1:0] ain, bin;
    logic         busy, done, div_by_zero;
    logic [N-1:0] result_hi, result_lo;

    seq_muldiv #(.N(N)) dut (
        .clk(clk), .resetb(resetb), .start(start), .op_div(op_div), .op_signed(op_signed),
        .ain(ain), .bin(bin), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
        int           lat;
        int           e0;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic         prev_done = 1'b1;
    logic [N-1:0] last_hi = '0;
    logic [N-1:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic, truncating division, latency from the operand bit length.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic d, input logic s);
        exp_t   e;
        longint va, vb, p, q, r, mag;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = s ? longint'($signed(b)) : longint'(b);
        e.dbz = 1'b0;
        e.e0  = 0;
        if (!d) begin
            p = va * vb;
            {e.hi, e.lo} = p[2*N-1:0];
            mag   = (vb < 0) ? -vb : vb;
            e.lat = 1;
            while (mag > 0) begin
                e.lat++;
                mag = mag >> 1;
            end
        end else if (b == '0) begin
            e.hi  = a;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q = va / vb;
            r = va % vb;
            e.lo  = q[N-1:0];
            e.hi  = r[N-1:0];
            e.lat = N + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!resetb) begin
            prev_done = 1'b1;
        end else begin
            check("done_busy_complement", {31'd0, done ^ busy}, 32'd1);
            if (done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("result_hi", {16'd0, result_hi}, {16'd0, e.hi});
                    check("result_lo", {16'd0, result_lo}, {16'd0, e.lo});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("latency", 32'(cyc - e.e0), 32'(e.lat));
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end else begin
                check("hold_hi", {16'd0, result_hi}, {16'd0, last_hi});
                check("hold_lo", {16'd0, result_lo}, {16'd0, last_lo});
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && !done; i++) @(negedge clk);
        if (!done) check("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic d, input logic s,
                         input bit poke);
        exp_t e;
        wait_idle();
        e = model(a, b, d, s);
        ain = a; bin = b; op_div = d; op_signed = s; start = 1'b1;
        @(negedge clk);
        e.e0 = cyc;
        sb_q.push_back(e);
        start = 1'b0;
        ain = N'($urandom); bin = N'($urandom); op_div = 1'($urandom); op_signed = 1'($urandom);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("dbz_cleared_on_accept", {31'd0, div_by_zero}, 32'd0);
        if (poke) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [N-1:0] a, b;
        start = 1'b0; op_div = 1'b0; op_signed = 1'b0; ain = '0; bin = '0;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", {16'd0, result_hi}, 32'd0);
        check("rst_lo", {16'd0, result_lo}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        issue(16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b0);
        issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        issue(16'hFFFD, 16'h0005, 1'b0, 1'b1, 1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        issue(16'd1000, 16'd7,    1'b1, 1'b0, 1'b0);
        issue(16'hFFF9, 16'h0002, 1'b1, 1'b1, 1'b0);
        issue(16'h8000, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        issue(16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        issue(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(16'h0007, 16'h0003, 1'b1, 1'b0, 1'b1);
        issue(16'h1234, 16'h00FF, 1'b0, 1'b0, 1'b1);
        issue(16'hABCD, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a divide: outputs drop to reset values at once.
        issue(16'd5000, 16'd3, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 resetb = 1'b0;
        #1;
        check("midrst_done", {31'd0, done}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", {16'd0, result_hi}, 32'd0);
        check("midrst_lo", {16'd0, result_lo}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        sb_q.delete();
        last_hi = '0;
        last_lo = '0;
        #2 resetb = 1'b1;

        for (int t = 0; t < 200; t++) begin
            a = N'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                2:       b = 16'h8000;
                3:       b = 16'hFFFF;
                default: b = N'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            issue(a, b, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_idle();
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
